// File: rtl/id_pipe_pkg.sv
// rtl/id_pipe_pkg.sv - shared decode constants for the ID stage
//
// Purpose : MIPS opcode/func encodings, internal op codes carried to EX,
//           and the codebase's reset / write-enable constants.
// Ports   : none (package).
package id_pipe_pkg;

  // Codebase-wide control constants
  localparam logic RST_ENABLE    = 1'b1;
  localparam logic WRITE_ENABLE  = 1'b1;
  localparam logic WRITE_DISABLE = 1'b0;

  // Primary opcodes (inst[31:26])
  localparam logic [5:0] EXE_SPECIAL = 6'b000000;
  localparam logic [5:0] EXE_ADDIU   = 6'b001001;
  localparam logic [5:0] EXE_ANDI    = 6'b001100;
  localparam logic [5:0] EXE_ORI     = 6'b001101;
  localparam logic [5:0] EXE_LUI     = 6'b001111;
  localparam logic [5:0] EXE_LW      = 6'b100011;
  localparam logic [5:0] EXE_SW      = 6'b101011;

  // SPECIAL func codes (inst[5:0])
  localparam logic [5:0] EXE_ADDU = 6'b100001;
  localparam logic [5:0] EXE_SUBU = 6'b100011;
  localparam logic [5:0] EXE_AND  = 6'b100100;
  localparam logic [5:0] EXE_OR   = 6'b100101;
  localparam logic [5:0] EXE_XOR  = 6'b100110;
  localparam logic [5:0] EXE_SLT  = 6'b101010;

  // Internal op codes handed to EX
  typedef enum logic [7:0] {
    OP_NOP   = 8'd0,
    OP_ADDIU = 8'd1,
    OP_ORI   = 8'd2,
    OP_ANDI  = 8'd3,
    OP_LUI   = 8'd4,
    OP_ADDU  = 8'd5,
    OP_SUBU  = 8'd6,
    OP_AND   = 8'd7,
    OP_OR    = 8'd8,
    OP_XOR   = 8'd9,
    OP_SLT   = 8'd10,
    OP_LW    = 8'd11,
    OP_SW    = 8'd12
  } id_op_e;

endpackage

// File: rtl/id_fwd_mux.sv
// rtl/id_fwd_mux.sv - operand-select priority mux for one register source
//
// Purpose : picks the operand for one source register: r0 -> 0, then the
//           instruction in ID/EX, then the MEM stage, then the regfile.
// Ports   : addr_i        source register address (0 when port unused)
//           ex_fwd_en_i   ID/EX holds a forwardable writer (valid, we, not LW)
//           ex_waddr_i    ID/EX destination
//           ex_fwd_data_i EX result of the ID/EX instruction
//           mem_we_i / mem_waddr_i / mem_wdata_i  MEM-stage writeback
//           rf_data_i     regfile read data
//           data_o        selected operand
module id_fwd_mux
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] addr_i,
  input  logic              ex_fwd_en_i,
  input  logic [REG_AW-1:0] ex_waddr_i,
  input  logic [DATA_W-1:0] ex_fwd_data_i,
  input  logic              mem_we_i,
  input  logic [REG_AW-1:0] mem_waddr_i,
  input  logic [DATA_W-1:0] mem_wdata_i,
  input  logic [DATA_W-1:0] rf_data_i,
  output logic [DATA_W-1:0] data_o
);

  always_comb begin
    data_o = rf_data_i;
    if (addr_i == '0) begin
      data_o = '0;
    end else if (ex_fwd_en_i && (ex_waddr_i == addr_i)) begin
      data_o = ex_fwd_data_i;
    end else if ((mem_we_i == WRITE_ENABLE) && (mem_waddr_i == addr_i)) begin
      data_o = mem_wdata_i;
    end
  end

endmodule

// File: rtl/id_pipe.sv
// rtl/id_pipe.sv - MIPS-subset decode stage with ID/EX register
//
// Purpose : decodes the IF instruction, reads the regfile, resolves hazards
//           by forwarding or a load-use bubble, and registers the result in
//           ID/EX with valid/ready handshakes on both sides.
// Option  : ID_ILLEGAL_TRAP_EN - flag unknown ops on ex_illegal and count
//           accepted illegal instructions in a saturating 8-bit counter.
// Ports   : clk, rst (sync, active-high), flush (kill ID/EX)
//           if_valid / id_ready / if_inst_addr / if_inst   IF side
//           reg1/2_addr_o, reg1/2_data_i                   regfile read ports
//           ex_fwd_data, mem_we/mem_waddr/mem_wdata        forwarding sources
//           ex_ready / ex_valid / ex_*                     EX side
module id_pipe
  import id_pipe_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int ADDR_W = 32,
  parameter int OP_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              if_valid,
  output logic              id_ready,
  input  logic [ADDR_W-1:0] if_inst_addr,
  input  logic [31:0]       if_inst,
  output logic [REG_AW-1:0] reg1_addr_o,
  output logic [REG_AW-1:0] reg2_addr_o,
  input  logic [DATA_W-1:0] reg1_data_i,
  input  logic [DATA_W-1:0] reg2_data_i,
  input  logic [DATA_W-1:0] ex_fwd_data,
  input  logic              mem_we,
  input  logic [REG_AW-1:0] mem_waddr,
  input  logic [DATA_W-1:0] mem_wdata,
  input  logic              ex_ready,
  output logic              ex_valid,
  output logic [OP_W-1:0]   ex_inst_op,
  output logic [DATA_W-1:0] ex_reg1_data,
  output logic [DATA_W-1:0] ex_reg2_data,
  output logic [DATA_W-1:0] ex_store_data,
  output logic              ex_we,
  output logic [REG_AW-1:0] ex_waddr,
  output logic [ADDR_W-1:0] ex_inst_addr,
  output logic              ex_illegal
);

  // Instruction fields
  logic [5:0]        opcode;
  logic [5:0]        func;
  logic [15:0]       imm;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;

  assign opcode = if_inst[31:26];
  assign func   = if_inst[5:0];
  assign imm    = if_inst[15:0];
  assign rs     = REG_AW'(if_inst[25:21]);
  assign rt     = REG_AW'(if_inst[20:16]);
  assign rd     = REG_AW'(if_inst[15:11]);

  logic [DATA_W-1:0] imm_sext;
  logic [DATA_W-1:0] imm_zext;
  logic [DATA_W-1:0] imm_lui;

  assign imm_sext = {{(DATA_W-16){imm[15]}}, imm};
  assign imm_zext = {{(DATA_W-16){1'b0}}, imm};
  assign imm_lui  = {imm, {(DATA_W-16){1'b0}}};

  // Decode results
  id_op_e            dec_op;
  logic              dec_re1;
  logic              dec_re2;
  logic              dec_we;
  logic [REG_AW-1:0] dec_waddr;
  logic              dec_use_imm;
  logic [DATA_W-1:0] dec_imm;
  logic              dec_illegal;

  always_comb begin
    dec_op      = OP_NOP;
    dec_re1     = 1'b0;
    dec_re2     = 1'b0;
    dec_we      = WRITE_DISABLE;
    dec_waddr   = '0;
    dec_use_imm = 1'b0;
    dec_imm     = '0;
    dec_illegal = 1'b0;
    unique case (opcode)
      EXE_SPECIAL: begin
        dec_re1   = 1'b1;
        dec_re2   = 1'b1;
        dec_we    = WRITE_ENABLE;
        dec_waddr = rd;
        unique case (func)
          EXE_ADDU: dec_op = OP_ADDU;
          EXE_SUBU: dec_op = OP_SUBU;
          EXE_AND:  dec_op = OP_AND;
          EXE_OR:   dec_op = OP_OR;
          EXE_XOR:  dec_op = OP_XOR;
          EXE_SLT:  dec_op = OP_SLT;
          default: begin
            // Unknown func: a NOP that reads and writes nothing
            dec_re1     = 1'b0;
            dec_re2     = 1'b0;
            dec_we      = WRITE_DISABLE;
            dec_waddr   = '0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      EXE_ADDIU: begin
        dec_op = OP_ADDIU; dec_re1 = 1'b1; dec_we = WRITE_ENABLE;
        dec_waddr = rt; dec_use_imm = 1'b1; dec_imm = imm_sext;
      end
      EXE_ORI: begin
        dec_op = OP_ORI; dec_re1 = 1'b1; dec_we = WRITE_ENABLE;
        dec_waddr = rt; dec_use_imm = 1'b1; dec_imm = imm_zext;
      end
      EXE_ANDI: begin
        dec_op = OP_ANDI; dec_re1 = 1'b1; dec_we = WRITE_ENABLE;
        dec_waddr = rt; dec_use_imm = 1'b1; dec_imm = imm_zext;
      end
      EXE_LUI: begin
        dec_op = OP_LUI; dec_we = WRITE_ENABLE;
        dec_waddr = rt; dec_use_imm = 1'b1; dec_imm = imm_lui;
      end
      EXE_LW: begin
        dec_op = OP_LW; dec_re1 = 1'b1; dec_we = WRITE_ENABLE;
        dec_waddr = rt; dec_use_imm = 1'b1; dec_imm = imm_sext;
      end
      EXE_SW: begin
        dec_op = OP_SW; dec_re1 = 1'b1; dec_re2 = 1'b1;
        dec_use_imm = 1'b1; dec_imm = imm_sext;
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  // Unused read ports present address 0 so they never forward or stall
  assign reg1_addr_o = dec_re1 ? rs : '0;
  assign reg2_addr_o = dec_re2 ? rt : '0;

  // ID/EX register
  logic              ex_valid_q;
  id_op_e            ex_op_q;
  logic [DATA_W-1:0] ex_reg1_q;
  logic [DATA_W-1:0] ex_reg2_q;
  logic [DATA_W-1:0] ex_store_q;
  logic              ex_we_q;
  logic [REG_AW-1:0] ex_waddr_q;
  logic [ADDR_W-1:0] ex_pc_q;

  // A load's data is not ready in EX, so it is never forwarded from there
  logic ex_fwd_en;
  assign ex_fwd_en = ex_valid_q && ex_we_q && (ex_op_q != OP_LW);

  logic [DATA_W-1:0] src1_data;
  logic [DATA_W-1:0] src2_data;

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd1 (
    .addr_i        (reg1_addr_o),
    .ex_fwd_en_i   (ex_fwd_en),
    .ex_waddr_i    (ex_waddr_q),
    .ex_fwd_data_i (ex_fwd_data),
    .mem_we_i      (mem_we),
    .mem_waddr_i   (mem_waddr),
    .mem_wdata_i   (mem_wdata),
    .rf_data_i     (reg1_data_i),
    .data_o        (src1_data)
  );

  id_fwd_mux #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_fwd2 (
    .addr_i        (reg2_addr_o),
    .ex_fwd_en_i   (ex_fwd_en),
    .ex_waddr_i    (ex_waddr_q),
    .ex_fwd_data_i (ex_fwd_data),
    .mem_we_i      (mem_we),
    .mem_waddr_i   (mem_waddr),
    .mem_wdata_i   (mem_wdata),
    .rf_data_i     (reg2_data_i),
    .data_o        (src2_data)
  );

  // Values loaded into ID/EX on accept
  logic [DATA_W-1:0] ex_reg2_d;
  logic [DATA_W-1:0] ex_store_d;
  logic              ex_we_d;

  assign ex_reg2_d  = dec_use_imm ? dec_imm : src2_data;
  assign ex_store_d = (dec_op == OP_SW) ? src2_data : '0;
  assign ex_we_d    = dec_we && (dec_waddr != '0);

  // Address-0 read ports can never match because ex_waddr_q != 0 is required
  logic load_use;
  assign load_use = ex_valid_q && (ex_op_q == OP_LW) && (ex_waddr_q != '0) &&
                    ((reg1_addr_o == ex_waddr_q) || (reg2_addr_o == ex_waddr_q));

  logic accept;
  assign id_ready = (rst != RST_ENABLE) && !flush && !load_use &&
                    (ex_ready || !ex_valid_q);
  assign accept   = if_valid && id_ready;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ex_valid_q <= 1'b0;
      ex_op_q    <= OP_NOP;
      ex_reg1_q  <= '0;
      ex_reg2_q  <= '0;
      ex_store_q <= '0;
      ex_we_q    <= WRITE_DISABLE;
      ex_waddr_q <= '0;
      ex_pc_q    <= '0;
    end else if (flush) begin
      ex_valid_q <= 1'b0;
    end else if (!ex_ready && ex_valid_q) begin
      ex_valid_q <= ex_valid_q;
    end else if (load_use) begin
      ex_valid_q <= 1'b0;
    end else if (accept) begin
      ex_valid_q <= 1'b1;
      ex_op_q    <= dec_op;
      ex_reg1_q  <= src1_data;
      ex_reg2_q  <= ex_reg2_d;
      ex_store_q <= ex_store_d;
      ex_we_q    <= ex_we_d;
      ex_waddr_q <= dec_waddr;
      ex_pc_q    <= if_inst_addr;
    end else begin
      ex_valid_q <= 1'b0;
    end
  end

  assign ex_valid      = ex_valid_q;
  assign ex_inst_op    = OP_W'(ex_op_q);
  assign ex_reg1_data  = ex_reg1_q;
  assign ex_reg2_data  = ex_reg2_q;
  assign ex_store_data = ex_store_q;
  assign ex_we         = ex_we_q;
  assign ex_waddr      = ex_waddr_q;
  assign ex_inst_addr  = ex_pc_q;

`ifdef ID_ILLEGAL_TRAP_EN
  logic       ex_illegal_q;
  logic [7:0] illegal_cnt_q;

  // accept is only true in the load branch above, so it tracks ID/EX loads
  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      ex_illegal_q  <= 1'b0;
      illegal_cnt_q <= '0;
    end else if (accept) begin
      ex_illegal_q <= dec_illegal;
      if (dec_illegal && (illegal_cnt_q != 8'hFF)) begin
        illegal_cnt_q <= illegal_cnt_q + 8'd1;
      end
    end
  end

  assign ex_illegal = ex_illegal_q;

  logic unused_bits;
  assign unused_bits = ^{if_inst[10:6]};
`else
  assign ex_illegal = 1'b0;

  logic unused_bits;
  assign unused_bits = ^{if_inst[10:6], dec_illegal};
`endif

endmodule

// File: tb/tb_id_pipe.sv
// tb/tb_id_pipe.sv - directed table-driven bench for id_pipe
module tb_id_pipe;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        if_valid;
  logic        id_ready;
  logic [31:0] if_inst_addr;
  logic [31:0] if_inst;
  logic [4:0]  reg1_addr_o;
  logic [4:0]  reg2_addr_o;
  logic [31:0] reg1_data_i;
  logic [31:0] reg2_data_i;
  logic [31:0] ex_fwd_data;
  logic        mem_we;
  logic [4:0]  mem_waddr;
  logic [31:0] mem_wdata;
  logic        ex_ready;
  logic        ex_valid;
  logic [7:0]  ex_inst_op;
  logic [31:0] ex_reg1_data;
  logic [31:0] ex_reg2_data;
  logic [31:0] ex_store_data;
  logic        ex_we;
  logic [4:0]  ex_waddr;
  logic [31:0] ex_inst_addr;
  logic        ex_illegal;

`ifdef ID_ILLEGAL_TRAP_EN
  localparam logic ILL_EN = 1'b1;
`else
  localparam logic ILL_EN = 1'b0;
`endif

  id_pipe dut (
    .clk(clk), .rst(rst), .flush(flush),
    .if_valid(if_valid), .id_ready(id_ready),
    .if_inst_addr(if_inst_addr), .if_inst(if_inst),
    .reg1_addr_o(reg1_addr_o), .reg2_addr_o(reg2_addr_o),
    .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
    .ex_fwd_data(ex_fwd_data),
    .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_inst_op(ex_inst_op),
    .ex_reg1_data(ex_reg1_data), .ex_reg2_data(ex_reg2_data),
    .ex_store_data(ex_store_data), .ex_we(ex_we), .ex_waddr(ex_waddr),
    .ex_inst_addr(ex_inst_addr), .ex_illegal(ex_illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Regfile model: r0 holds junk to prove the stage forces r0 to zero
  logic [31:0] rf [32];
  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual %h required %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] f);
    return {6'b000000, rs, rt, rd, 5'b00000, f};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [7:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
    logic        we;
    logic [4:0]  wa;
    logic        ill;
  } vec_t;

  localparam int NV = 16;
  vec_t vecs [NV];

  initial begin
    for (int i = 0; i < 32; i++) rf[i] = 32'h1000_0000 | i;
    rf[0] = 32'hBAD0_0000;
    rf[1] = 32'h0000_0005;

    vecs[0]  = '{itype(6'b001001, 5'd1, 5'd2, 16'hFFFF), 5'd1, 5'd0, 8'd1, 32'h5, 32'hFFFFFFFF, 32'h0, 1'b1, 5'd2, 1'b0};
    vecs[1]  = '{itype(6'b001101, 5'd3, 5'd6, 16'h8001), 5'd3, 5'd0, 8'd2, 32'h10000003, 32'h00008001, 32'h0, 1'b1, 5'd6, 1'b0};
    vecs[2]  = '{itype(6'b001100, 5'd4, 5'd7, 16'hF0F0), 5'd4, 5'd0, 8'd3, 32'h10000004, 32'h0000F0F0, 32'h0, 1'b1, 5'd7, 1'b0};
    vecs[3]  = '{itype(6'b001111, 5'd5, 5'd8, 16'h1234), 5'd0, 5'd0, 8'd4, 32'h0, 32'h12340000, 32'h0, 1'b1, 5'd8, 1'b0};
    vecs[4]  = '{rtype(5'd10, 5'd11, 5'd9, 6'b100001), 5'd10, 5'd11, 8'd5, 32'h1000000A, 32'h1000000B, 32'h0, 1'b1, 5'd9, 1'b0};
    vecs[5]  = '{rtype(5'd13, 5'd14, 5'd12, 6'b100011), 5'd13, 5'd14, 8'd6, 32'h1000000D, 32'h1000000E, 32'h0, 1'b1, 5'd12, 1'b0};
    vecs[6]  = '{rtype(5'd16, 5'd17, 5'd15, 6'b100100), 5'd16, 5'd17, 8'd7, 32'h10000010, 32'h10000011, 32'h0, 1'b1, 5'd15, 1'b0};
    vecs[7]  = '{rtype(5'd19, 5'd20, 5'd18, 6'b100101), 5'd19, 5'd20, 8'd8, 32'h10000013, 32'h10000014, 32'h0, 1'b1, 5'd18, 1'b0};
    vecs[8]  = '{rtype(5'd22, 5'd23, 5'd21, 6'b100110), 5'd22, 5'd23, 8'd9, 32'h10000016, 32'h10000017, 32'h0, 1'b1, 5'd21, 1'b0};
    vecs[9]  = '{rtype(5'd25, 5'd26, 5'd24, 6'b101010), 5'd25, 5'd26, 8'd10, 32'h10000019, 32'h1000001A, 32'h0, 1'b1, 5'd24, 1'b0};
    vecs[10] = '{rtype(5'd1, 5'd2, 5'd0, 6'b100001), 5'd1, 5'd2, 8'd5, 32'h5, 32'h10000002, 32'h0, 1'b0, 5'd0, 1'b0};
    vecs[11] = '{rtype(5'd0, 5'd1, 5'd3, 6'b100001), 5'd0, 5'd1, 8'd5, 32'h0, 32'h5, 32'h0, 1'b1, 5'd3, 1'b0};
    vecs[12] = '{itype(6'b100011, 5'd16, 5'd15, 16'hFFFC), 5'd16, 5'd0, 8'd11, 32'h10000010, 32'hFFFFFFFC, 32'h0, 1'b1, 5'd15, 1'b0};
    vecs[13] = '{itype(6'b101011, 5'd18, 5'd17, 16'h0008), 5'd18, 5'd17, 8'd12, 32'h10000012, 32'h00000008, 32'h10000011, 1'b0, 5'd0, 1'b0};
    vecs[14] = '{itype(6'b111111, 5'd1, 5'd2, 16'h0003), 5'd0, 5'd0, 8'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1};
    vecs[15] = '{rtype(5'd1, 5'd2, 5'd3, 6'b000000), 5'd0, 5'd0, 8'd0, 32'h0, 32'h0, 32'h0, 1'b0, 5'd0, 1'b1};

    rst = 1'b1; flush = 1'b0; if_valid = 1'b0; if_inst_addr = '0; if_inst = '0;
    ex_fwd_data = 32'hDEAD_BEEF; mem_we = 1'b0; mem_waddr = '0; mem_wdata = '0;
    ex_ready = 1'b1;

    // Reset
    #1;
    chk("rst id_ready", {31'b0, id_ready}, 32'd0);
    step; step;
    chk("rst ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rst ex_inst_op", {24'b0, ex_inst_op}, 32'd0);
    chk("rst ex_reg1_data", ex_reg1_data, 32'd0);
    chk("rst ex_we", {31'b0, ex_we}, 32'd0);
    chk("rst ex_inst_addr", ex_inst_addr, 32'd0);
    chk("rst ex_illegal", {31'b0, ex_illegal}, 32'd0);
    rst = 1'b0;
    #1;
    chk("post-rst id_ready", {31'b0, id_ready}, 32'd1);

    // Table: one instruction, then an idle cycle so nothing forwards
    for (int i = 0; i < NV; i++) begin
      if_inst = vecs[i].inst;
      if_inst_addr = 32'h400 + 32'(i * 4);
      if_valid = 1'b1;
      #1;
      chk($sformatf("v%0d reg1_addr", i), {27'b0, reg1_addr_o}, {27'b0, vecs[i].ra1});
      chk($sformatf("v%0d reg2_addr", i), {27'b0, reg2_addr_o}, {27'b0, vecs[i].ra2});
      chk($sformatf("v%0d id_ready", i), {31'b0, id_ready}, 32'd1);
      step;
      if_valid = 1'b0;
      chk($sformatf("v%0d ex_valid", i), {31'b0, ex_valid}, 32'd1);
      chk($sformatf("v%0d ex_inst_op", i), {24'b0, ex_inst_op}, {24'b0, vecs[i].op});
      chk($sformatf("v%0d ex_reg1_data", i), ex_reg1_data, vecs[i].a);
      chk($sformatf("v%0d ex_reg2_data", i), ex_reg2_data, vecs[i].b);
      chk($sformatf("v%0d ex_store_data", i), ex_store_data, vecs[i].st);
      chk($sformatf("v%0d ex_we", i), {31'b0, ex_we}, {31'b0, vecs[i].we});
      chk($sformatf("v%0d ex_waddr", i), {27'b0, ex_waddr}, {27'b0, vecs[i].wa});
      chk($sformatf("v%0d ex_inst_addr", i), ex_inst_addr, 32'h400 + 32'(i * 4));
      chk($sformatf("v%0d ex_illegal", i), {31'b0, ex_illegal}, {31'b0, vecs[i].ill & ILL_EN});
      step;
      chk($sformatf("v%0d idle ex_valid", i), {31'b0, ex_valid}, 32'd0);
    end
`ifdef ID_ILLEGAL_TRAP_EN
    chk("illegal count after table", {24'b0, dut.illegal_cnt_q}, 32'd2);
`endif

    // Forwarding: ID/EX writer of r1 (EX result 7), MEM writes r2 = 9
    if_inst = itype(6'b001001, 5'd0, 5'd1, 16'h0007); if_valid = 1'b1;
    step;
    ex_fwd_data = 32'h7; mem_we = 1'b1; mem_waddr = 5'd2; mem_wdata = 32'h9;
    if_inst = rtype(5'd1, 5'd2, 5'd3, 6'b100001);
    step;
    chk("fwd ex rs", ex_reg1_data, 32'h7);
    chk("fwd mem rt", ex_reg2_data, 32'h9);
    // EX beats MEM when both write the same register
    mem_waddr = 5'd3;
    if_inst = rtype(5'd3, 5'd3, 5'd4, 6'b100001);
    step;
    chk("fwd prio rs", ex_reg1_data, 32'h7);
    chk("fwd prio rt", ex_reg2_data, 32'h7);
    mem_we = 1'b0; if_valid = 1'b0; ex_fwd_data = 32'hDEAD_BEEF;
    step;

    // Load-use: LW r4,0(r1) then OR r5,r4,r4
    if_inst = itype(6'b100011, 5'd1, 5'd4, 16'h0000); if_valid = 1'b1;
    step;
    if_inst = rtype(5'd4, 5'd4, 5'd5, 6'b100101);
    #1;
    chk("lu id_ready stall", {31'b0, id_ready}, 32'd0);
    step;
    chk("lu bubble ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("lu id_ready after bubble", {31'b0, id_ready}, 32'd1);
    mem_we = 1'b1; mem_waddr = 5'd4; mem_wdata = 32'hCAFE_0004;
    step;
    mem_we = 1'b0; if_valid = 1'b0;
    chk("lu issue ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("lu issue op", {24'b0, ex_inst_op}, 32'd8);
    chk("lu mem fwd rs", ex_reg1_data, 32'hCAFE_0004);
    chk("lu mem fwd rt", ex_reg2_data, 32'hCAFE_0004);
    chk("lu waddr", {27'b0, ex_waddr}, 32'd5);
    step;

    // Backpressure: EX stalls for 3 cycles while ID/EX holds ADDIU
    if_inst = vecs[0].inst; if_inst_addr = 32'h800; if_valid = 1'b1;
    step;
    ex_ready = 1'b0;
    if_inst = vecs[1].inst; if_inst_addr = 32'h804;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk($sformatf("bp%0d id_ready", k), {31'b0, id_ready}, 32'd0);
      step;
      chk($sformatf("bp%0d ex_valid", k), {31'b0, ex_valid}, 32'd1);
      chk($sformatf("bp%0d ex_inst_op", k), {24'b0, ex_inst_op}, 32'd1);
      chk($sformatf("bp%0d ex_reg1_data", k), ex_reg1_data, 32'h5);
      chk($sformatf("bp%0d ex_reg2_data", k), ex_reg2_data, 32'hFFFFFFFF);
      chk($sformatf("bp%0d ex_inst_addr", k), ex_inst_addr, 32'h800);
    end
    ex_ready = 1'b1;
    #1;
    chk("bp release id_ready", {31'b0, id_ready}, 32'd1);
    step;
    chk("bp next op", {24'b0, ex_inst_op}, 32'd2);
    chk("bp next pc", ex_inst_addr, 32'h804);

    // Flush while ID/EX is valid
    if_inst = vecs[0].inst;
    flush = 1'b1;
    #1;
    chk("flush id_ready", {31'b0, id_ready}, 32'd0);
    step;
    flush = 1'b0;
    chk("flush ex_valid", {31'b0, ex_valid}, 32'd0);

    // Reset in the middle of a load-use stall
    if_inst = itype(6'b100011, 5'd1, 5'd4, 16'h0000); if_inst_addr = 32'h900;
    step;
    if_inst = rtype(5'd4, 5'd4, 5'd5, 6'b100101);
    #1;
    chk("rs stall id_ready", {31'b0, id_ready}, 32'd0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rs ex_valid", {31'b0, ex_valid}, 32'd0);
    chk("rs ex_inst_op", {24'b0, ex_inst_op}, 32'd0);
    chk("rs ex_reg1_data", ex_reg1_data, 32'd0);
    chk("rs ex_waddr", {27'b0, ex_waddr}, 32'd0);
    chk("rs ex_inst_addr", ex_inst_addr, 32'd0);
    #1;
    chk("rs id_ready after", {31'b0, id_ready}, 32'd1);

    // Illegal opcode straight after reset
    if_inst = itype(6'b111111, 5'd0, 5'd0, 16'h0000);
    step;
    if_valid = 1'b0;
    chk("ill ex_valid", {31'b0, ex_valid}, 32'd1);
    chk("ill op", {24'b0, ex_inst_op}, 32'd0);
    chk("ill we", {31'b0, ex_we}, 32'd0);
    chk("ill ex_illegal", {31'b0, ex_illegal}, {31'b0, ILL_EN});
`ifdef ID_ILLEGAL_TRAP_EN
    chk("illegal count after reset", {24'b0, dut.illegal_cnt_q}, 32'd1);
`endif
    step;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
